// File: rtl/clock_mux_switch_ctrl.sv
// ---------------------------------------------------------------------------
// clock_mux_switch_ctrl
//
// Glitch-safe select sequencer for an N-input clock mux built from hardened
// mux and clock-gate cells. Runs entirely on an always-on reference clock.
// A select change is performed as: close the output gate, wait GATE_WAIT
// cycles, move the mux select, wait SETTLE_WAIT cycles, reopen the gate and
// acknowledge. The mux select only ever moves while the gate is closed.
//
// Ports:
//   clk      - always-on reference clock, rising edge
//   rst_n    - asynchronous active-low reset
//   sw_req   - single-cycle switch request, sampled only while idle
//   sw_sel   - requested mux input, valid with sw_req
//   sw_ack   - one-cycle pulse: switch complete (or select already active)
//   sw_err   - one-cycle pulse: requested input does not exist
//   sw_busy  - high during a switch sequence and during startup
//   mux_sel  - registered select to the hardened mux cell
//   gate_en  - registered enable to the output clock-gate cell
// ---------------------------------------------------------------------------
module clock_mux_switch_ctrl #(
    parameter int NUM_IN      = 4,
    parameter int SEL_W       = 2,
    parameter int DEF_SEL     = 0,
    parameter int GATE_WAIT   = 4,
    parameter int SETTLE_WAIT = 8,
    parameter int CNT_W       = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sw_req,
    input  logic [SEL_W-1:0] sw_sel,
    output logic             sw_ack,
    output logic             sw_err,
    output logic             sw_busy,
    output logic [SEL_W-1:0] mux_sel,
    output logic             gate_en
);

    localparam int MAX_WAIT = (GATE_WAIT > SETTLE_WAIT) ? GATE_WAIT : SETTLE_WAIT;

    localparam logic [CNT_W-1:0] GATE_RLD   = CNT_W'(GATE_WAIT - 1);
    localparam logic [CNT_W-1:0] SETTLE_RLD = CNT_W'(SETTLE_WAIT - 1);
    localparam logic [SEL_W-1:0] DEF_SEL_V  = SEL_W'(DEF_SEL);

    // Parameter sanity checks, evaluated at elaboration.
    if (NUM_IN < 2 || NUM_IN > 16) begin : g_chk_num_in
        $error("clock_mux_switch_ctrl: NUM_IN must be 2..16");
    end
    if ((1 << SEL_W) < NUM_IN) begin : g_chk_sel_w
        $error("clock_mux_switch_ctrl: SEL_W too narrow for NUM_IN");
    end
    if (DEF_SEL < 0 || DEF_SEL >= NUM_IN) begin : g_chk_def_sel
        $error("clock_mux_switch_ctrl: DEF_SEL out of range");
    end
    if (GATE_WAIT < 1 || SETTLE_WAIT < 1) begin : g_chk_waits
        $error("clock_mux_switch_ctrl: wait counts must be >= 1");
    end
    if ((MAX_WAIT - 1) >= (1 << CNT_W)) begin : g_chk_cnt_w
        $error("clock_mux_switch_ctrl: CNT_W cannot hold the largest wait");
    end

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        GATE_OFF = 2'd1,
        SETTLE   = 2'd2
    } state_e;

    state_e           state_q,   state_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;
    logic [SEL_W-1:0] mux_sel_q, mux_sel_d;
    logic [SEL_W-1:0] pend_q,    pend_d;
    logic             gate_en_q, gate_en_d;
    logic             busy_q,    busy_d;
    logic             ack_q,     ack_d;
    logic             err_q,     err_d;
    // startup_q suppresses the acknowledge at the end of the reset settle.
    logic             startup_q, startup_d;
    // same_q delays the acknowledge of an already-active select by one cycle
    // so it appears one cycle after the request edge.
    logic             same_q,    same_d;

    logic sel_invalid;
    assign sel_invalid = (32'(sw_sel) >= 32'(NUM_IN));

    // State register; reset lands in SETTLE so the startup sequence reuses
    // the normal settle path with the gate closed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= SETTLE;
            cnt_q     <= SETTLE_RLD;
            mux_sel_q <= DEF_SEL_V;
            pend_q    <= DEF_SEL_V;
            gate_en_q <= 1'b0;
            busy_q    <= 1'b1;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
            startup_q <= 1'b1;
            same_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            mux_sel_q <= mux_sel_d;
            pend_q    <= pend_d;
            gate_en_q <= gate_en_d;
            busy_q    <= busy_d;
            ack_q     <= ack_d;
            err_q     <= err_d;
            startup_q <= startup_d;
            same_q    <= same_d;
        end
    end

    // Next-state and output logic. The mux select is only written in the
    // GATE_OFF exit, where the gate has already been closed for GATE_WAIT
    // cycles and stays closed for SETTLE_WAIT more.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mux_sel_d = mux_sel_q;
        pend_d    = pend_q;
        gate_en_d = gate_en_q;
        busy_d    = busy_q;
        ack_d     = same_q;
        err_d     = 1'b0;
        startup_d = startup_q;
        same_d    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (sw_req) begin
                    if (sel_invalid) begin
                        err_d = 1'b1;
                    end else if (sw_sel == mux_sel_q) begin
                        same_d = 1'b1;
                    end else begin
                        pend_d    = sw_sel;
                        gate_en_d = 1'b0;
                        busy_d    = 1'b1;
                        state_d   = GATE_OFF;
                        cnt_d     = GATE_RLD;
                    end
                end
            end
            GATE_OFF: begin
                if (cnt_q == '0) begin
                    mux_sel_d = pend_q;
                    state_d   = SETTLE;
                    cnt_d     = SETTLE_RLD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            SETTLE: begin
                if (cnt_q == '0) begin
                    gate_en_d = 1'b1;
                    busy_d    = 1'b0;
                    ack_d     = ~startup_q;
                    startup_d = 1'b0;
                    state_d   = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                // Unreachable encoding: close the gate and resettle safely.
                gate_en_d = 1'b0;
                busy_d    = 1'b1;
                state_d   = SETTLE;
                cnt_d     = SETTLE_RLD;
            end
        endcase
    end

    assign sw_ack  = ack_q;
    assign sw_err  = err_q;
    assign sw_busy = busy_q;
    assign mux_sel = mux_sel_q;
    assign gate_en = gate_en_q;

endmodule

// File: tb/tb_clock_mux_switch_ctrl.sv
// ---------------------------------------------------------------------------
// tb_clock_mux_switch_ctrl
//
// Directed bench for clock_mux_switch_ctrl configured with three inputs so
// that select value 3 is out of range. Acknowledge/error pulses are checked
// by a scoreboard monitor against expectations queued at request time; the
// stimulus thread additionally checks gate/select timing at fixed cycles.
// ---------------------------------------------------------------------------
module tb_clock_mux_switch_ctrl;

    localparam int NUM_IN      = 3;
    localparam int SEL_W       = 2;
    localparam int DEF_SEL     = 0;
    localparam int GATE_WAIT   = 4;
    localparam int SETTLE_WAIT = 8;
    localparam int CNT_W       = 4;

    logic             clk    = 1'b0;
    logic             rst_n  = 1'b0;
    logic             sw_req = 1'b0;
    logic [SEL_W-1:0] sw_sel = '0;
    logic             sw_ack;
    logic             sw_err;
    logic             sw_busy;
    logic [SEL_W-1:0] mux_sel;
    logic             gate_en;

    clock_mux_switch_ctrl #(
        .NUM_IN      (NUM_IN),
        .SEL_W       (SEL_W),
        .DEF_SEL     (DEF_SEL),
        .GATE_WAIT   (GATE_WAIT),
        .SETTLE_WAIT (SETTLE_WAIT),
        .CNT_W       (CNT_W)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .sw_req  (sw_req),
        .sw_sel  (sw_sel),
        .sw_ack  (sw_ack),
        .sw_err  (sw_err),
        .sw_busy (sw_busy),
        .mux_sel (mux_sel),
        .gate_en (gate_en)
    );

    // Reference clock, 10 ns period.
    always #5 clk = ~clk;

    // Rising-edge counter; read only on falling edges so it is stable.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef enum int {EV_NONE = 0, EV_ACK = 1, EV_ERR = 2} ev_kind_e;

    typedef struct {
        ev_kind_e         kind;
        int               cycle;
        logic [SEL_W-1:0] mux;
    } exp_t;

    exp_t expQ[$];

    int nAsserts = 0;
    int nFails   = 0;

    // Single comparison point: every check steps the counters here.
    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        nAsserts++;
        if (act !== exp) begin
            nFails++;
            $display("[TB] FAIL %s: actual %0d, expected %0d (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    // Wait on falling edges until the edge counter reaches target, bounded.
    task automatic waitCycle(input int target);
        int guard = 0;
        while (cyc < target && guard < 1000) begin
            @(negedge clk);
            guard++;
        end
        checkOutput("waitCycle reached", cyc, target);
    endtask

    // Issue a one-cycle request on the next rising edge t and queue the
    // expected pulse (if any) at t+delay. Returns with cyc == t.
    task automatic applyStimulus(input logic [SEL_W-1:0] sel,
                                 input ev_kind_e kind, input int delay,
                                 input logic [SEL_W-1:0] expMux,
                                 output int t);
        exp_t e;
        sw_req = 1'b1;
        sw_sel = sel;
        t      = cyc + 1;
        if (kind != EV_NONE) begin
            e.kind  = kind;
            e.cycle = t + delay;
            e.mux   = expMux;
            expQ.push_back(e);
        end
        @(negedge clk);
        sw_req = 1'b0;
        sw_sel = SEL_W'($urandom_range(3, 0));
    endtask

    // Scoreboard: pop one expectation per observed pulse.
    task automatic handleEvent(input ev_kind_e k);
        exp_t e;
        if (expQ.size() == 0) begin
            nAsserts++;
            nFails++;
            $display("[TB] FAIL unexpected pulse: actual kind %0d, expected none (cycle %0d)",
                     k, cyc);
        end else begin
            e = expQ.pop_front();
            checkOutput("pulse kind",    32'(k),  32'(e.kind));
            checkOutput("pulse cycle",   cyc,     e.cycle);
            checkOutput("pulse mux_sel", mux_sel, e.mux);
            checkOutput("pulse gate_en", gate_en, 1);
            checkOutput("pulse sw_busy", sw_busy, 0);
        end
    endtask

    // Monitor: scoreboard pulses and the rule that the select only moves
    // while the gate is closed both before and after.
    logic             prevGate = 1'b0;
    logic [SEL_W-1:0] prevMux  = '0;
    always @(negedge clk) begin
        if (sw_ack === 1'b1) handleEvent(EV_ACK);
        if (sw_err === 1'b1) handleEvent(EV_ERR);
        if (rst_n && mux_sel !== prevMux)
            checkOutput("mux_sel moved with gate open", 32'(gate_en | prevGate), 0);
        prevGate = gate_en;
        prevMux  = mux_sel;
    end

    // Watchdog so the run always ends.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: actual timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed sequence.
    initial begin
        int t;
        int t2;
        int r;

        // Reset values while held in reset.
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset gate_en", gate_en, 0);
        checkOutput("reset mux_sel", mux_sel, DEF_SEL);
        checkOutput("reset sw_busy", sw_busy, 1);
        checkOutput("reset sw_ack",  sw_ack,  0);
        checkOutput("reset sw_err",  sw_err,  0);

        // Startup: gate opens on the 8th edge after release, no ack.
        r = cyc;
        rst_n = 1'b1;
        waitCycle(r + 7);
        checkOutput("startup gate_en before", gate_en, 0);
        checkOutput("startup busy before",    sw_busy, 1);
        waitCycle(r + 8);
        checkOutput("startup gate_en after", gate_en, 1);
        checkOutput("startup busy after",    sw_busy, 0);
        checkOutput("startup mux_sel",       mux_sel, 0);
        repeat (2) @(negedge clk);

        // Full switch 0 -> 2.
        applyStimulus(2'd2, EV_ACK, 12, 2'd2, t);
        checkOutput("sw02 gate_en at t", gate_en, 0);
        checkOutput("sw02 busy at t",    sw_busy, 1);
        checkOutput("sw02 mux_sel at t", mux_sel, 0);
        waitCycle(t + 3);
        checkOutput("sw02 mux_sel at t+3", mux_sel, 0);
        waitCycle(t + 4);
        checkOutput("sw02 mux_sel at t+4", mux_sel, 2);
        checkOutput("sw02 gate_en at t+4", gate_en, 0);
        waitCycle(t + 11);
        checkOutput("sw02 gate_en at t+11", gate_en, 0);
        checkOutput("sw02 busy at t+11",    sw_busy, 1);
        waitCycle(t + 12);
        checkOutput("sw02 gate_en at t+12", gate_en, 1);
        checkOutput("sw02 busy at t+12",    sw_busy, 0);
        @(negedge clk);

        // Same select: ack one cycle later, gate never drops.
        applyStimulus(2'd2, EV_ACK, 1, 2'd2, t);
        checkOutput("same gate_en at t", gate_en, 1);
        checkOutput("same busy at t",    sw_busy, 0);
        waitCycle(t + 1);
        checkOutput("same gate_en at t+1", gate_en, 1);
        checkOutput("same mux_sel at t+1", mux_sel, 2);
        waitCycle(t + 3);

        // Invalid select: one error pulse, nothing else moves.
        applyStimulus(2'd3, EV_ERR, 0, 2'd2, t);
        checkOutput("inval gate_en", gate_en, 1);
        checkOutput("inval busy",    sw_busy, 0);
        waitCycle(t + 3);
        checkOutput("inval mux_sel after", mux_sel, 2);

        // Switch 2 -> 1 with an ignored request while busy.
        applyStimulus(2'd1, EV_ACK, 12, 2'd1, t);
        waitCycle(t + 4);
        sw_req = 1'b1;
        sw_sel = 2'd0;
        @(negedge clk);
        sw_req = 1'b0;
        waitCycle(t + 11);
        checkOutput("busy gate_en at t+11", gate_en, 0);
        checkOutput("busy mux_sel at t+11", mux_sel, 1);
        waitCycle(t + 12);
        checkOutput("busy mux_sel final", mux_sel, 1);

        // Back-to-back request right after the ack.
        applyStimulus(2'd0, EV_ACK, 12, 2'd0, t2);
        checkOutput("b2b request edge", t2, t + 13);
        checkOutput("b2b gate_en at t", gate_en, 0);
        waitCycle(t2 + 12);
        checkOutput("b2b mux_sel final", mux_sel, 0);
        checkOutput("b2b gate_en final", gate_en, 1);
        @(negedge clk);

        // Reset in the middle of a 0 -> 2 switch: no ack for it.
        applyStimulus(2'd2, EV_NONE, 0, 2'd0, t);
        waitCycle(t + 6);
        checkOutput("rstmid mux_sel before", mux_sel, 2);
        checkOutput("rstmid gate_en before", gate_en, 0);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("rstmid async gate_en", gate_en, 0);
        checkOutput("rstmid async mux_sel", mux_sel, 0);
        checkOutput("rstmid async busy",    sw_busy, 1);
        @(negedge clk);
        @(negedge clk);
        r = cyc;
        rst_n = 1'b1;
        waitCycle(r + 7);
        checkOutput("rstmid restart gate_en before", gate_en, 0);
        waitCycle(r + 8);
        checkOutput("rstmid restart gate_en after", gate_en, 1);
        checkOutput("rstmid restart mux_sel",       mux_sel, 0);

        // Every queued expectation must have been matched.
        repeat (20) @(negedge clk);
        checkOutput("scoreboard drained", expQ.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
        $finish;
    end

endmodule

// File: doc/clock_mux_switch_ctrl.md
Name: clock_mux_switch_ctrl

Overview:
Parametrised, glitch-safe selection controller for an N-input clock mux built from hardened mux and gate cells.
- Runs on a single always-on reference clock.
- Accepts select-change requests and sequences the change: gate off the output clock, wait, change the mux select, wait for the mux to settle, re-enable the gate, acknowledge.
- The mux select is never changed while the downstream clock gate is open.
- Sits beside the hardened mux/gate cells in the clocking block and drives their static select and enable.

Parameters:
NUM_IN, 4, number of clock inputs on the controlled mux (2..16)
SEL_W, 2, select width; must be >= clog2(NUM_IN)
DEF_SEL, 0, mux select loaded at reset
GATE_WAIT, 4, cycles between gate deassert and select change (>=1)
SETTLE_WAIT, 8, cycles between select change and gate reassert (>=1)
CNT_W, 4, wait-counter width; must hold max(GATE_WAIT, SETTLE_WAIT)-1

Ports:
clk  input  1  always-on reference clock; all logic on rising edge
rst_n  input  1  asynchronous active-low reset
sw_req  input  1  switch request; single-cycle pulse, sampled only when idle
sw_sel  input  SEL_W  requested input index, valid with sw_req
sw_ack  output  1  one-cycle pulse: switch complete, gate reopened
sw_err  output  1  one-cycle pulse: request rejected (sw_sel >= NUM_IN)
sw_busy  output  1  high while a sequence (or reset startup) is in progress
mux_sel  output  SEL_W  registered select to the hardened mux cell
gate_en  output  1  registered enable to the output clock-gate cell

Behaviour:
- Clock and reset: clk with asynchronous active-low rst_n, as already decided.
- All outputs are registered; no combinational path from any input to any output.
- Reset values: mux_sel=DEF_SEL, gate_en=0, sw_busy=1, sw_ack=0, sw_err=0, state=SETTLE, counter=SETTLE_WAIT-1.
- Startup:
  - After rst_n release the block counts SETTLE_WAIT cycles in SETTLE, then sets gate_en=1, sw_busy=0, state=IDLE.
  - No sw_ack is issued for startup.
- States: IDLE, GATE_OFF, SETTLE. The counter decrements each cycle in GATE_OFF/SETTLE and is reloaded on each state entry.
- IDLE, on sw_req=1 at edge t, checked in this order:
  - sw_sel >= NUM_IN: sw_err=1 for one cycle; nothing else changes; stay IDLE.
  - sw_sel == mux_sel: sw_ack=1 for one cycle at t+1; gate_en stays 1; no sequence run.
  - Otherwise: latch sw_sel into a pending register; gate_en=0, sw_busy=1, state=GATE_OFF, counter=GATE_WAIT-1.
- GATE_OFF, counter==0: mux_sel=pending; state=SETTLE; counter=SETTLE_WAIT-1.
- SETTLE, counter==0: gate_en=1, sw_ack=1 (one cycle), sw_busy=0, state=IDLE.
- Timing for a full switch:
  - gate_en low for exactly GATE_WAIT+SETTLE_WAIT cycles.
  - mux_sel changes exactly GATE_WAIT cycles after gate_en falls.
  - sw_ack coincides with gate_en rise.
- Invariant: mux_sel never changes in a cycle where gate_en=1 or gate_en changes.
- sw_req while sw_busy=1 is ignored: no ack, no err, pending register unchanged. The requester must wait for !sw_busy.
- sw_sel is don't-care when sw_req=0.
- Reset mid-sequence: all state returns to reset values immediately (asynchronous). gate_en drops at once, mux_sel reverts to DEF_SEL, the startup sequence reruns, and no ack is issued for the aborted request.
- Back-to-back: a sw_req in the cycle after sw_ack (sw_busy=0) is accepted normally.
- Counter width: CNT_W must hold the largest wait-1 (elaboration check recommended). Counter never wraps; it stops at 0 on state exit.

Test Plan:
- Reset/startup (defaults): release rst_n -> gate_en=0, mux_sel=0, sw_busy=1 for 8 cycles, then gate_en=1, sw_busy=0, no sw_ack.
- Full switch 0->2: sw_req with sw_sel=2 at edge t -> gate_en=0 at t; mux_sel=2 at t+4; gate_en=1, sw_ack pulse, sw_busy=0 at t+12; assert mux_sel stable whenever gate_en=1.
- Same select: mux_sel=2, sw_req with sw_sel=2 -> sw_ack at t+1; gate_en never drops; mux_sel unchanged.
- Invalid select (NUM_IN=3, SEL_W=2): sw_req with sw_sel=3 -> one sw_err pulse; gate_en, mux_sel, sw_busy unchanged; no sw_ack.
- Request while busy: during 0->1 switch, sw_req with sw_sel=3 at t+5 -> ignored; final mux_sel=1; exactly one sw_ack at t+12.
- Reset mid-sequence: assert rst_n=0 at t+6 of a 0->3 switch -> gate_en=0 and mux_sel=0 asynchronously; after release, startup repeats; no sw_ack observed.
